// File: rtl/iterative_sqrt_pkg.sv
// iterative_sqrt_pkg: shared FSM state type and width helpers for the iterative square-root engine
package iterative_sqrt_pkg;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  function automatic int root_w(input int width);
    return width / 2;
  endfunction
  function automatic bit width_ok(input int width);
    return (width >= 2) && (width % 2 == 0);
  endfunction
endpackage

// File: rtl/iterative_sqrt_if.sv
// iterative_sqrt_if: operand/result valid-ready bundle; carries remainder when ITERATIVE_SQRT_REMAINDER_EN is defined
interface iterative_sqrt_if
  import iterative_sqrt_pkg::*;
#(
  parameter int WIDTH = 8
);
  localparam int ROOT_W = root_w(WIDTH);
  logic [WIDTH-1:0]  n;
  logic              n_vld;
  logic              n_rdy;
  logic [ROOT_W-1:0] result;
  logic              result_vld;
  logic              result_rdy;
  logic              busy;
`ifdef ITERATIVE_SQRT_REMAINDER_EN
  logic [ROOT_W:0]   remainder;
  modport master(output n, n_vld, result_rdy, input n_rdy, result, result_vld, busy, remainder);
  modport slave(input n, n_vld, result_rdy, output n_rdy, result, result_vld, busy, remainder);
`else
  modport master(output n, n_vld, result_rdy, input n_rdy, result, result_vld, busy);
  modport slave(input n, n_vld, result_rdy, output n_rdy, result, result_vld, busy);
`endif
endinterface

// File: rtl/iterative_sqrt_step.sv
// iterative_sqrt_step: one restoring digit of the square-root recurrence (combinational)
module iterative_sqrt_step #(
  parameter int ROOT_W = 4
) (
  input  logic [ROOT_W+1:0] i_rem,
  input  logic [ROOT_W-1:0] i_root,
  input  logic [1:0]        i_bits,
  output logic [ROOT_W+1:0] o_rem,
  output logic [ROOT_W-1:0] o_root
);
  logic [ROOT_W+1:0] w_shift;
  logic [ROOT_W+1:0] w_trial;
  logic              w_ge;
  // bring down two operand bits, try root*4+1, keep the difference if it fits
  always_comb begin
    w_shift = (i_rem << 2) | (ROOT_W+2)'(i_bits);
    w_trial = {i_root, 2'b01};
    w_ge    = w_shift >= w_trial;
    o_rem   = w_ge ? w_shift - w_trial : w_shift;
    o_root  = (i_root << 1) | ROOT_W'(w_ge);
  end
endmodule

// File: rtl/iterative_sqrt_engine.sv
// iterative_sqrt_engine: multi-cycle floor(sqrt(n)), one root bit per clock; ITERATIVE_SQRT_REMAINDER_EN adds the remainder output
module iterative_sqrt_engine
  import iterative_sqrt_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input logic clk,
  input logic rst,
  iterative_sqrt_if.slave bus
);
  localparam int ROOT_W = root_w(WIDTH);
  localparam int CNT_W  = ROOT_W > 1 ? $clog2(ROOT_W) : 1;
  if (!width_ok(WIDTH)) begin : g_width_check
    $error("iterative_sqrt_engine: WIDTH=%0d must be even and >= 2", WIDTH);
  end
  state_t            r_state;
  state_t            w_next;
  logic [ROOT_W+1:0] r_rem;
  logic [ROOT_W+1:0] w_rem;
  logic [ROOT_W-1:0] r_root;
  logic [ROOT_W-1:0] w_root;
  logic [ROOT_W-1:0] r_result;
  logic [WIDTH-1:0]  r_op;
  logic [CNT_W-1:0]  r_cnt;
  logic              w_accept;
  logic              w_last;
  iterative_sqrt_step #(.ROOT_W(ROOT_W)) u_step (
    .i_rem  (r_rem),
    .i_root (r_root),
    .i_bits (r_op[WIDTH-1 -: 2]),
    .o_rem  (w_rem),
    .o_root (w_root)
  );
  // state register, reset returns to IDLE and drops any in-flight operation
  always_ff @(posedge clk) r_state <= !rst ? IDLE : w_next;
  // next state and handshake outputs
  always_comb begin
    w_accept       = r_state == IDLE && bus.n_vld;
    w_last         = r_state == BUSY && r_cnt == '0;
    w_next         = w_accept ? BUSY : w_last ? DONE : (r_state == DONE && bus.result_rdy) ? IDLE : r_state;
    bus.n_rdy      = r_state == IDLE;
    bus.busy       = r_state == BUSY;
    bus.result_vld = r_state == DONE;
    bus.result     = r_result;
  end
  // datapath: load on accept, one recurrence step per BUSY cycle, capture root on the final step
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_rem    <= '0;
      r_root   <= '0;
      r_op     <= '0;
      r_cnt    <= '0;
      r_result <= '0;
    end else if (w_accept) begin
      r_op   <= bus.n;
      r_rem  <= '0;
      r_root <= '0;
      r_cnt  <= CNT_W'(ROOT_W - 1);
    end else if (r_state == BUSY) begin
      r_rem  <= w_rem;
      r_root <= w_root;
      r_op   <= r_op << 2;
      r_cnt  <= r_cnt - 1'b1;
      if (w_last) r_result <= w_root;
    end
  end
`ifdef ITERATIVE_SQRT_REMAINDER_EN
  logic [ROOT_W:0] r_remainder;
  // final remainder never exceeds 2*root, so ROOT_W+1 bits hold it exactly
  always_ff @(posedge clk) begin
    if (!rst) r_remainder <= '0;
    else if (w_last) r_remainder <= w_rem[ROOT_W:0];
  end
  assign bus.remainder = r_remainder;
`endif
endmodule

// File: tb/tb_iterative_sqrt_engine.sv
// tb_iterative_sqrt_engine: directed vectors, backpressure, mid-op reset and exhaustive 8-bit sweep
module tb_iterative_sqrt_engine;
  logic clk = 0;
  logic rst = 0;
  always #5 clk = ~clk;
  iterative_sqrt_if #(.WIDTH(8))  b8();
  iterative_sqrt_if #(.WIDTH(16)) b16();
  iterative_sqrt_engine #(.WIDTH(8))  dut8  (.clk(clk), .rst(rst), .bus(b8));
  iterative_sqrt_engine #(.WIDTH(16)) dut16 (.clk(clk), .rst(rst), .bus(b16));
  int checks = 0;
  int errors = 0;
  int hs8 = 0;
  bit sel = 0;
  logic       vld, nrdy, bsy;
  logic [7:0] res;
  assign vld  = sel ? b16.result_vld : b8.result_vld;
  assign nrdy = sel ? b16.n_rdy : b8.n_rdy;
  assign bsy  = sel ? b16.busy : b8.busy;
  assign res  = sel ? b16.result : {4'b0, b8.result};
`ifdef ITERATIVE_SQRT_REMAINDER_EN
  logic [8:0] rmd;
  assign rmd = sel ? b16.remainder : {4'b0, b8.remainder};
`endif
  always @(posedge clk) if (rst && b8.result_vld && b8.result_rdy) hs8 <= hs8 + 1;
  typedef struct {
    bit          wide;
    logic [15:0] n;
    logic [7:0]  root;
    logic [8:0]  rem;
    int          lat;
  } vec_t;
  vec_t vt [7];
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input bit v, input logic [15:0] n);
    if (sel) begin
      b16.n = n;
      b16.n_vld = v;
    end else begin
      b8.n = n[7:0];
      b8.n_vld = v;
    end
  endtask
  function automatic int isqrt(input int v);
    int r;
    r = 0;
    while ((r + 1) * (r + 1) <= v) r++;
    return r;
  endfunction
  task automatic run_op(input logic [15:0] n, input logic [7:0] er, input logic [8:0] erm, input int elat, input string tag);
    int lat;
    check({tag, " n_rdy"}, nrdy, 1);
    drive(1, n);
    tick;
    drive(0, 16'h0);
    lat = 1;
    while (!vld && lat < 40) begin
      tick;
      lat++;
    end
    check({tag, " latency"}, lat, elat);
    check({tag, " result"}, res, er);
`ifdef ITERATIVE_SQRT_REMAINDER_EN
    check({tag, " remainder"}, rmd, erm);
`else
    if (erm > 9'd510) check({tag, " remainder range"}, erm, 0);
`endif
    tick;
    check({tag, " vld one cycle"}, vld, 0);
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int g;
    bit got;
    int hs0;
    vt[0] = '{0, 144, 12, 0, 5};
    vt[1] = '{0, 143, 11, 22, 5};
    vt[2] = '{0, 255, 15, 30, 5};
    vt[3] = '{0, 0, 0, 0, 5};
    vt[4] = '{1, 65535, 255, 510, 9};
    vt[5] = '{1, 65025, 255, 0, 9};
    vt[6] = '{1, 1, 1, 0, 9};
    b8.n = 0; b8.n_vld = 0; b8.result_rdy = 1;
    b16.n = 0; b16.n_vld = 0; b16.result_rdy = 1;
    tick;
    tick;
    check("reset n_rdy", b8.n_rdy, 1);
    check("reset result_vld", b8.result_vld, 0);
    check("reset busy", b8.busy, 0);
    check("reset result", b8.result, 0);
    check("reset busy16", b16.busy, 0);
`ifdef ITERATIVE_SQRT_REMAINDER_EN
    check("reset remainder", b8.remainder, 0);
`endif
    rst = 1;
    tick;
    for (int i = 0; i < 7; i++) begin
      sel = vt[i].wide;
      run_op(vt[i].n, vt[i].root, vt[i].rem, vt[i].lat, $sformatf("vec%0d", i));
    end
    sel = 0;
    b8.result_rdy = 0;
    drive(1, 200);
    tick;
    drive(0, 0);
    g = 0;
    while (!vld && g < 40) begin
      tick;
      g++;
    end
    check("bp vld rise", vld, 1);
    drive(1, 9);
    for (int i = 0; i < 6; i++) begin
      check("bp result held", res, 14);
      check("bp vld held", vld, 1);
      check("bp n_rdy", nrdy, 0);
`ifdef ITERATIVE_SQRT_REMAINDER_EN
      check("bp remainder held", rmd, 4);
`endif
      tick;
    end
    drive(0, 0);
    b8.result_rdy = 1;
    tick;
    check("bp release n_rdy", nrdy, 1);
    check("bp release vld", vld, 0);
    check("bp no accept", bsy, 0);
    check("bp result retained", res, 14);
    drive(1, 255);
    tick;
    drive(0, 0);
    tick;
    check("pre-reset busy", bsy, 1);
    rst = 0;
    tick;
    rst = 1;
    check("midrst vld", vld, 0);
    check("midrst busy", bsy, 0);
    check("midrst n_rdy", nrdy, 1);
    check("midrst result", res, 0);
    tick;
    check("midrst no output", vld, 0);
    run_op(49, 7, 0, 5, "post-reset");
    hs0 = hs8;
    for (int v = 0; v < 256; v++) begin
      g = 0;
      got = 0;
      b8.result_rdy = 0;
      drive(1, 16'(v));
      tick;
      drive(0, 0);
      while (!got && g < 60) begin
        b8.result_rdy = 1'($urandom_range(0, 1));
        if (vld && b8.result_rdy) begin
          check($sformatf("sweep result n=%0d", v), res, isqrt(v));
`ifdef ITERATIVE_SQRT_REMAINDER_EN
          check($sformatf("sweep remainder n=%0d", v), rmd, v - isqrt(v) * isqrt(v));
`endif
          got = 1;
        end
        tick;
        g++;
      end
      check($sformatf("sweep handshake n=%0d", v), got, 1);
    end
    b8.result_rdy = 1;
    tick;
    check("sweep handshake count", hs8 - hs0, 256);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/iterative_sqrt_engine.md
Name: iterative_sqrt_engine

Overview:
Parametrised multi-cycle integer square root with full valid/ready handshakes on both channels, including output backpressure. Computes floor(sqrt(n)) by restoring digit-by-digit recurrence, one result bit per clock. Successor to the fixed 8-bit sqrt proc. Drops into the same benchmark top level, where a start/valid shim drives the input channel and result_rdy may now be driven by a consumer.

Parameters:
WIDTH, 8, input operand width; must be even and >= 2; elaboration error otherwise.
ROOT_W, WIDTH/2, derived result width; not overridable.

Ports:
clk  input  1  single clock, all state on rising edge
rst  input  1  synchronous reset, active-low (0 = reset)
n  input  WIDTH  operand
n_vld  input  1  operand valid
n_rdy  output  1  engine can accept operand
result  output  ROOT_W  floor(sqrt(n))
result_vld  output  1  result valid
result_rdy  input  1  consumer accepts result
busy  output  1  high while iterating (state BUSY)

Behaviour:
- Reset (rst==0 at edge): state IDLE. n_rdy=1 after reset; result=0, result_vld=0, busy=0; internal rem, root, op and counter cleared. Reset overrides everything, including mid-BUSY and mid-DONE; in-flight operation discarded, no output produced.
- FSM states: IDLE, BUSY, DONE.
- IDLE: n_rdy=1. On edge with n_vld&&n_rdy: latch op=n, rem=0, root=0, cnt=ROOT_W-1; go BUSY.
- BUSY: n_rdy=0, busy=1. Each edge performs one step:
  - rem' = (rem<<2)|op[WIDTH-1:WIDTH-2]
  - trial = (root<<2)|1
  - if rem' >= trial: rem=rem'-trial, root=(root<<1)|1; else rem=rem', root=root<<1.
  - op<<=2.
  - cnt decrements; step taken with cnt==0 moves to DONE.
- Widths: rem and trial are ROOT_W+2 bits; root is ROOT_W bits; no truncation permitted in the compare.
- DONE: result=root, result_vld=1, n_rdy=0. On edge with result_rdy=1: go IDLE, result_vld=0.
- result is held stable while result_vld=1 and result_rdy=0; indefinite stall is legal.
- result_rdy is ignored when result_vld=0.
- Latency: accept on edge E0, ROOT_W BUSY steps on edges E1..E_ROOT_W; result_vld high in the cycle following E_ROOT_W.
  - Throughput: one operation per ROOT_W+2 cycles with result_rdy held high.
- n_vld held high in BUSY/DONE is not consumed. The next operation is accepted only once IDLE is re-entered.
- n and n_vld need not be stable outside the accept edge.
- result retains the last root value after leaving DONE; it is meaningful only when result_vld=1.
- Boundaries:
  - n=0 -> 0.
  - n=2^WIDTH-1 -> 2^ROOT_W-1.
  - WIDTH=2 gives a single-step operation.

Optional Feature:
ITERATIVE_SQRT_REMAINDER_EN
- Defined: adds output port remainder [ROOT_W:0] = n - result^2, valid and stable under the same result_vld/result_rdy rules as result; reset value 0.
- Undefined: port absent; rem is internal only. Core timing is identical in both builds.

Decomposition:
- Package iterative_sqrt_pkg:
  - state enum (IDLE, BUSY, DONE);
  - function root_w(width) returning width/2;
  - width-check constant/function used by the elaboration assertion.
- One sub-module iterative_sqrt_step: purely combinational, inputs rem/root/top-2-bits, outputs next rem/root; parametrised by ROOT_W. Keeps the recurrence unit-testable exhaustively for small widths.

Test Plan:
- WIDTH=8, result_rdy=1, n=144, 143, 255, 0 back-to-back:
  - results 12, 11, 15, 0;
  - remainders (REMAINDER_EN) 0, 22, 30, 0;
  - each result_vld exactly 5 cycles after its accept edge, one cycle wide.
- WIDTH=16, n=65535 -> 255 (remainder 510); n=65025 -> 255 (remainder 0); n=1 -> 1; latency 9 cycles.
- Backpressure, WIDTH=8, n=200:
  - hold result_rdy=0 for 6 cycles after result_vld rises -> result=14 stable, n_rdy=0, a new n_vld is not accepted;
  - release -> IDLE and n_rdy=1 next cycle.
- Reset mid-op: accept n=255, drive rst=0 on the 2nd BUSY cycle -> next cycle result_vld=0, busy=0, n_rdy=1. A subsequent n=49 returns 7 with normal latency.
- Exhaustive WIDTH=8 sweep of n=0..255 against a floor-sqrt model with random result_rdy stalls -> every result correct, no lost or duplicated results.
- Reset values checked before first operation, and WIDTH=7 elaboration fails the width assertion.
